chroma_block_serializer: RTL

Buffers one set of four upsampled 8x8 chroma blocks produced by the 4:2:0 supersampling stage and streams them out one 8-sample row per cycle under a valid/ready handshake. It sits between chroma supersampling and the colour-conversion/output stage, converting the wide parallel result into a narrow back-pressurable stream. It holds a single block set at a time and accepts the next set in the same cycle the last row of the current set leaves, so a full set costs no bubble.

---
 rtl/chroma_block_serializer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/chroma_block_serializer.sv
`default_nettype none
// ============================================================================
// Module      : chroma_block_serializer
// Description : Holds one set of four upsampled 8x8 chroma blocks and streams
//               it out one 8-sample row per cycle under valid/ready. A new
//               set can be taken in the same cycle the final row leaves, so
//               back-to-back sets run without a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module chroma_block_serializer (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [1:0]                  ch,
  input  logic [3:0]                  valid_in,
  input  logic signed [7:0][7:0][8:0] block_1_in,
  input  logic signed [7:0][7:0][8:0] block_2_in,
  input  logic signed [7:0][7:0][8:0] block_3_in,
  input  logic signed [7:0][7:0][8:0] block_4_in,
  output logic                        in_ready,
  output logic signed [7:0][8:0]      row_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [1:0]                  out_ch,
  output logic [1:0]                  out_blk,
  output logic [2:0]                  out_row,
  output logic                        out_last,
  output logic                        err_partial
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  localparam logic [3:0] C_ALL_VALID = 4'hF;
  localparam logic [1:0] C_CH_CB     = 2'b01;
  localparam logic [1:0] C_CH_CR     = 2'b10;

  state_t          state;
  logic [1:0]      ch_q;
  logic [1:0]      blk_q;
  logic [2:0]      row_q;
  logic            last_q;
  logic            err_q;

  // Block set storage, indexed [block][row][col]; never reset, since row_out
  // is only meaningful while out_valid is high.
  logic [7:0][7:0][8:0] buffer [4];

  logic w_xfer;
  logic w_set_full;
  logic w_ch_ok;
  logic w_capture;
  logic w_partial;

  assign out_valid  = (state == ST_STREAM);
  assign w_xfer     = out_valid && out_ready;
  // The slot frees up when idle or when the final row of the set is leaving.
  assign in_ready   = (state == ST_IDLE) || (w_xfer && last_q);
  assign w_set_full = (valid_in == C_ALL_VALID);
  // Only Cb and Cr are legal channels; anything else is silently dropped.
  assign w_ch_ok    = (ch == C_CH_CB) || (ch == C_CH_CR);
  assign w_capture  = in_ready && w_set_full && w_ch_ok;
  assign w_partial  = in_ready && (valid_in != 4'h0) && !w_set_full;

  assign out_ch      = ch_q;
  assign out_blk     = blk_q;
  assign out_row     = row_q;
  assign out_last    = last_q;
  assign err_partial = err_q;
  assign row_out     = buffer[blk_q][row_q];

  // Load the whole block set when a capture is accepted.
  always_ff @(posedge clock) begin
    if (w_capture) begin
      buffer[0] <= block_1_in;
      buffer[1] <= block_2_in;
      buffer[2] <= block_3_in;
      buffer[3] <= block_4_in;
    end
  end

  // Control FSM: capture, row/block sequencing, last-row flag and error pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      ch_q   <= 2'b00;
      blk_q  <= 2'd0;
      row_q  <= 3'd0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= w_partial;
      if (w_capture) begin
        // Covers both a capture from idle and one overlapping the final row.
        state  <= ST_STREAM;
        ch_q   <= ch;
        blk_q  <= 2'd0;
        row_q  <= 3'd0;
        last_q <= 1'b0;
      end else if (w_xfer) begin
        if (last_q) begin
          state  <= ST_IDLE;
          blk_q  <= 2'd0;
          row_q  <= 3'd0;
          last_q <= 1'b0;
        end else begin
          // Row counter wraps 7 -> 0 naturally; block advances on that wrap.
          row_q <= row_q + 3'd1;
          if (row_q == 3'd7) begin
            blk_q <= blk_q + 2'd1;
          end
          last_q <= (blk_q == 2'd3) && (row_q == 3'd6);
        end
      end
    end
  end

endmodule
`default_nettype wire
